// File: rtl/rect_fill_seq.sv
// Rectangle plotter: latches two corners and a colour, then streams every pixel of a
// solid or outlined rectangle in row-major order through a ready-gated plot port.
module rect_fill_seq #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           Clock,
    input  logic           reset_N,
    input  logic           start,
    input  logic           abort,
    input  logic           outline,
    input  logic [X_W-1:0] x1,
    input  logic [X_W-1:0] x2,
    input  logic [Y_W-1:0] y1,
    input  logic [Y_W-1:0] y2,
    input  logic [2:0]     colour_in,
    input  logic           plot_ready,
    output logic           plot,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [2:0]     colour_out,
    output logic           busy,
    output logic           doneSq
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    state_t         state, next_state;
    logic           setup_phase;
    logic           outline_q;
    logic [X_W-1:0] x1_q, x2_q, xmin, xmax;
    logic [Y_W-1:0] y1_q, y2_q, ymin, ymax;
    logic           accept;
    logic           last_pixel;
    logic           skip_interior;

    assign accept        = (state == RUN) && plot_ready;
    assign last_pixel    = (x_out == xmax) && (y_out == ymax);
    assign skip_interior = outline_q && (x_out == xmin) && (y_out != ymin) && (y_out != ymax);

    always_ff @(posedge Clock or negedge reset_N) begin
        if (!reset_N) state <= IDLE;
        else          state <= next_state;
    end

    // SETUP spends one cycle registering the bounds and one loading the start pixel.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start && !abort) next_state = SETUP;
            SETUP: if (abort) next_state = IDLE;
                   else if (setup_phase) next_state = RUN;
            RUN:   if (abort) next_state = IDLE;
                   else if (accept && last_pixel) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        plot   = (state == RUN);
        busy   = (state != IDLE);
        doneSq = (state == DONE) && !abort;
    end

    // The xmax test comes before any increment, so the top column never wraps.
    always_ff @(posedge Clock or negedge reset_N) begin
        if (!reset_N) begin
            setup_phase <= 1'b0;
            outline_q   <= 1'b0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            xmin        <= '0;
            xmax        <= '0;
            ymin        <= '0;
            ymax        <= '0;
            x_out       <= '0;
            y_out       <= '0;
            colour_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        x1_q        <= x1;
                        x2_q        <= x2;
                        y1_q        <= y1;
                        y2_q        <= y2;
                        outline_q   <= outline;
                        colour_out  <= colour_in;
                        setup_phase <= 1'b0;
                    end
                end
                SETUP: begin
                    if (!abort) begin
                        if (!setup_phase) begin
                            xmin        <= (x1_q < x2_q) ? x1_q : x2_q;
                            xmax        <= (x1_q < x2_q) ? x2_q : x1_q;
                            ymin        <= (y1_q < y2_q) ? y1_q : y2_q;
                            ymax        <= (y1_q < y2_q) ? y2_q : y1_q;
                            setup_phase <= 1'b1;
                        end else begin
                            x_out <= xmin;
                            y_out <= ymin;
                        end
                    end
                end
                RUN: begin
                    if (!abort && accept && !last_pixel) begin
                        if (x_out == xmax) begin
                            x_out <= xmin;
                            y_out <= y_out + 1'b1;
                        end else if (skip_interior) begin
                            x_out <= xmax;
                        end else begin
                            x_out <= x_out + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_seq.sv
// Self-checking bench for rect_fill_seq: each pixel stream is compared against a
// list built directly from the rectangle geometry.
module tb_rect_fill_seq;

    logic       Clock;
    logic       reset_N;
    logic       start;
    logic       abort;
    logic       outline;
    logic [7:0] x1, x2;
    logic [6:0] y1, y2;
    logic [2:0] colour_in;
    logic       plot_ready;
    logic       plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       busy;
    logic       doneSq;

    int checks = 0;
    int errors = 0;
    int exp_x[$];
    int exp_y[$];

    rect_fill_seq #(.X_W(8), .Y_W(7)) dut (
        .Clock(Clock), .reset_N(reset_N), .start(start), .abort(abort),
        .outline(outline), .x1(x1), .x2(x2), .y1(y1), .y2(y2),
        .colour_in(colour_in), .plot_ready(plot_ready), .plot(plot),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .busy(busy), .doneSq(doneSq)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Every pixel of the rectangle in row-major order; outline keeps only border pixels.
    task automatic build_expected(input int xa, input int xb, input int ya, input int yb, input bit ol);
        int xl, xh, yl, yh;
        xl = (xa < xb) ? xa : xb;  xh = (xa < xb) ? xb : xa;
        yl = (ya < yb) ? ya : yb;  yh = (ya < yb) ? yb : ya;
        exp_x.delete();
        exp_y.delete();
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                if (!ol || y == yl || y == yh || x == xl || x == xh) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                end
    endtask

    task automatic issue_start(input int xa, input int xb, input int ya, input int yb,
                               input bit ol, input logic [2:0] col);
        @(posedge Clock); #1;
        start = 1'b1; x1 = 8'(xa); x2 = 8'(xb); y1 = 7'(ya); y2 = 7'(yb);
        outline = ol; colour_in = col; plot_ready = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        x1 = 8'($urandom); x2 = 8'($urandom); y1 = 7'($urandom); y2 = 7'($urandom);
        outline = 1'($urandom); colour_in = 3'($urandom);
    endtask

    // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1
    task automatic run_rect(input int xa, input int xb, input int ya, input int yb,
                            input bit ol, input logic [2:0] col, input int mode, input string name);
        bit done_seen, last_acc, held;
        int hx, hy, cyc;
        build_expected(xa, xb, ya, yb, ol);
        issue_start(xa, xb, ya, yb, ol, col);
        @(negedge Clock);
        checks++;
        if (plot !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s latency1: plot=%b busy=%b, required plot=0 busy=1", name, plot, busy);
        end
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (plot !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s latency2: plot=%b, required 0", name, plot);
        end
        done_seen = 0; last_acc = 0; held = 0; hx = 0; hy = 0; cyc = 0;
        while (!done_seen && cyc < 3000) begin
            @(posedge Clock); #1;
            case (mode)
                0:       plot_ready = 1'b1;
                1:       plot_ready = 1'($urandom_range(0, 1));
                default: plot_ready = ((cyc % 4) == 1 || (cyc % 4) == 2) ? 1'b0 : 1'b1;
            endcase
            @(negedge Clock);
            checks++;
            if (last_acc) begin
                done_seen = 1;
                if (doneSq !== 1'b1 || plot !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s done: doneSq=%b plot=%b, required doneSq=1 plot=0", name, doneSq, plot);
                end
            end else begin
                if (plot !== 1'b1 || doneSq !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s run: plot=%b doneSq=%b, required plot=1 doneSq=0 (%0d pixels left)",
                             name, plot, doneSq, exp_x.size());
                end
                if (held) begin
                    checks++;
                    if (int'(x_out) != hx || int'(y_out) != hy) begin
                        errors++;
                        $display("[TB] FAIL %s hold: (%0d,%0d), required (%0d,%0d)", name, x_out, y_out, hx, hy);
                    end
                end
                if (plot_ready) begin
                    checks++;
                    if (int'(x_out) != exp_x[0] || int'(y_out) != exp_y[0] || colour_out !== col) begin
                        errors++;
                        $display("[TB] FAIL %s pixel: (%0d,%0d) c=%0d, required (%0d,%0d) c=%0d",
                                 name, x_out, y_out, colour_out, exp_x[0], exp_y[0], col);
                    end
                    void'(exp_x.pop_front());
                    void'(exp_y.pop_front());
                    if (exp_x.size() == 0) last_acc = 1;
                    held = 0;
                end else begin
                    held = 1; hx = int'(x_out); hy = int'(y_out);
                end
            end
            cyc++;
        end
        if (!done_seen) begin
            errors++;
            $display("[TB] FAIL %s timeout: done not reached, required completion", name);
        end
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (busy !== 1'b0 || doneSq !== 1'b0 || plot !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s after: busy=%b doneSq=%b plot=%b, required all 0", name, busy, doneSq, plot);
        end
    endtask

    task automatic test_reset();
        reset_N = 1'b0; start = 1'b0; abort = 1'b0; outline = 1'b0;
        x1 = '0; x2 = '0; y1 = '0; y2 = '0; colour_in = '0; plot_ready = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if ({plot, busy, doneSq, x_out, y_out, colour_out} !== '0) begin
            errors++;
            $display("[TB] FAIL reset: plot=%b busy=%b done=%b x=%0d y=%0d c=%0d, required all 0",
                     plot, busy, doneSq, x_out, y_out, colour_out);
        end
        reset_N = 1'b1;
    endtask

    task automatic test_abort();
        int acc;
        bit finished;
        build_expected(2, 4, 3, 4, 1'b0);
        issue_start(2, 4, 3, 4, 1'b0, 3'd5);
        @(posedge Clock);
        acc = 0; finished = 0;
        for (int c = 0; c < 50 && !finished; c++) begin
            @(posedge Clock); #1;
            plot_ready = 1'b1;
            if (acc == 2) abort = 1'b1;
            @(negedge Clock);
            checks++;
            if (int'(x_out) != exp_x[acc] || int'(y_out) != exp_y[acc] || plot !== 1'b1) begin
                errors++;
                $display("[TB] FAIL abort pixel%0d: (%0d,%0d) plot=%b, required (%0d,%0d) plot=1",
                         acc, x_out, y_out, plot, exp_x[acc], exp_y[acc]);
            end
            if (acc == 2) begin
                @(posedge Clock); #1;
                abort = 1'b0;
                @(negedge Clock);
                checks++;
                if (plot !== 1'b0 || busy !== 1'b0 || doneSq !== 1'b0 || x_out !== 8'd4 || y_out !== 7'd3) begin
                    errors++;
                    $display("[TB] FAIL abort idle: plot=%b busy=%b done=%b (%0d,%0d), required 0 0 0 (4,3)",
                             plot, busy, doneSq, x_out, y_out);
                end
                finished = 1;
            end
            acc++;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            checks++;
            if (doneSq !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort quiet: doneSq=%b busy=%b, required 0 0", doneSq, busy);
            end
        end
        run_rect(2, 4, 3, 4, 1'b0, 3'd2, 0, "after_abort");
    endtask

    task automatic test_reset_mid_run();
        issue_start(0, 9, 0, 9, 1'b0, 3'd7);
        repeat (20) @(posedge Clock);
        @(negedge Clock); #1;
        reset_N = 1'b0;
        #1;
        checks++;
        if ({plot, busy, doneSq, x_out, y_out, colour_out} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset: plot=%b busy=%b done=%b x=%0d y=%0d c=%0d, required all 0",
                     plot, busy, doneSq, x_out, y_out, colour_out);
        end
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        reset_N = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            checks++;
            if (doneSq !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset idle: done=%b busy=%b plot=%b, required 0 0 0", doneSq, busy, plot);
            end
        end
        run_rect(1, 3, 1, 2, 1'b1, 3'd4, 0, "after_reset");
    endtask

    task automatic test_random();
        int xa, xb, ya, yb;
        for (int i = 0; i < 12; i++) begin
            xa = $urandom_range(0, 255);
            xb = xa + $urandom_range(0, 6) - 3;
            if (xb < 0) xb = 0;
            if (xb > 255) xb = 255;
            ya = $urandom_range(0, 127);
            yb = ya + $urandom_range(0, 6) - 3;
            if (yb < 0) yb = 0;
            if (yb > 127) yb = 127;
            run_rect(xa, xb, ya, yb, 1'($urandom), 3'($urandom), 1, "random");
        end
    endtask

    initial begin
        test_reset();
        run_rect(2, 4, 3, 4, 1'b0, 3'd3, 0, "fill");
        run_rect(4, 2, 4, 3, 1'b0, 3'd6, 0, "swapped");
        run_rect(0, 3, 0, 3, 1'b1, 3'd1, 0, "outline");
        run_rect(5, 5, 10, 14, 1'b1, 3'd2, 0, "outline_thin");
        run_rect(2, 4, 3, 4, 1'b0, 3'd5, 2, "ready_toggle");
        run_rect(159, 159, 119, 119, 1'b0, 3'd7, 0, "single");
        run_rect(255, 250, 127, 124, 1'b0, 3'd3, 1, "edge_fill");
        run_rect(250, 255, 124, 127, 1'b1, 3'd4, 0, "edge_outline");
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rect_fill_seq.md
RECT_FILL_SEQ -- requirements
Module: rect_fill_seq

Interface
REQ-001 Parameter X_W, default 8, x coordinate width (160-column frame).
REQ-002 Parameter Y_W, default 7, y coordinate width (120-row frame).
REQ-003 Clock  input  1  rising-edge system clock.
REQ-004 reset_N  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; sampled only in IDLE; begins a rectangle.
REQ-006 abort  input  1  level; cancels any operation in progress.
REQ-007 outline  input  1  sampled with start; 1 = perimeter only, 0 = solid fill.
REQ-008 x1, x2  input  X_W each  corner x coordinates, sampled with start.
REQ-009 y1, y2  input  Y_W each  corner y coordinates, sampled with start.
REQ-010 colour_in  input  3  RGB colour, sampled with start.
REQ-011 plot_ready  input  1  downstream (VGA write port) accepts the current pixel this cycle.
REQ-012 plot  output  1  pixel valid.
REQ-013 x_out / y_out  output  X_W / Y_W  current pixel coordinate.
REQ-014 colour_out  output  3  latched colour.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 doneSq  output  1  one-cycle pulse: rectangle completed.

Function
REQ-017 FSM states IDLE, SETUP, RUN, DONE; all registered outputs update on Clock rising edge.
REQ-018 IDLE: start=1 and abort=0 -> latch inputs, go to SETUP; otherwise stay.
REQ-019 SETUP: compute xmin=min(x1,x2), xmax=max(x1,x2), ymin, ymax likewise (unsigned compare); load x_out=xmin, y_out=ymin; go to RUN.
REQ-020 Latency: start sampled at edge N -> plot=1 with first pixel after edge N+2.
REQ-021 RUN: plot=1; pixel advances only on a cycle with plot=1 and plot_ready=1 (accepted).
REQ-022 plot_ready=0: x_out, y_out, colour_out, plot held unchanged.
REQ-023 Scan order row-major: x increments; x==xmax accepted -> x_out=xmin, y_out+1.
REQ-024 outline=1, interior row (ymin<y<ymax): after xmin accepted, next x is xmax (interior skipped); if xmin==xmax, row holds one pixel.
REQ-025 outline=1 on rows ymin and ymax: full span, identical to fill.
REQ-026 Acceptance of (xmax,ymax) -> DONE; plot=0 from the following cycle.
REQ-027 DONE: doneSq=1 for exactly one cycle, then IDLE; start held high re-triggers only from IDLE (earliest one cycle after DONE).
REQ-028 Degenerate rectangle x1==x2 and y1==y2: exactly one pixel plotted, then DONE.
REQ-029 Pixel count fill = (xmax-xmin+1)*(ymax-ymin+1); outline = that count minus interior, never a duplicated pixel.
REQ-030 start, corner, colour, outline inputs ignored while busy=1.
REQ-031 abort=1 in SETUP, RUN or DONE -> IDLE next edge, plot=0, doneSq=0 (no done pulse), coordinates held; abort beats start in IDLE.
REQ-032 Coordinate arithmetic in X_W / Y_W bits; no wrap: xmax/ymax detection precedes increment, so xmax=2^X_W-1 must not overflow.

Reset
REQ-033 reset_N=0 asynchronously forces IDLE, plot=0, busy=0, doneSq=0, x_out=0, y_out=0, colour_out=0, latched corners=0.
REQ-034 Reset mid-RUN: no doneSq; after release, block sits in IDLE until a fresh start.

Verification
REQ-035 Fill (2,3)-(4,4), plot_ready=1: pixels (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) on consecutive cycles, doneSq one cycle after last.
REQ-036 Swapped corners x1=4,y1=4,x2=2,y2=3: identical sequence to REQ-035.
REQ-037 Outline (0,0)-(3,3): 12 pixels, (1,1),(2,1),(1,2),(2,2) never emitted, doneSq once.
REQ-038 plot_ready toggled 1,0,0,1 during fill: coordinates held during 0 cycles, no pixel skipped or repeated.
REQ-039 abort at third pixel of REQ-035: IDLE next edge, plot=0, no doneSq; subsequent start completes normally.
REQ-040 Single pixel (159,119) and reset_N pulsed mid-RUN on a 10x10 fill: one pixel then doneSq; reset yields all outputs zero, no doneSq.
